// File: rtl/doce_tl_pkg.sv
// Shared definitions for the DOCE transport-layer AXI-Stream blocks:
// stream widths, arbiter FSM encoding and a constant-width helper.
package doce_tl_pkg;

    localparam int DATA_W = 128;
    localparam int KEEP_W = DATA_W / 8;
    localparam int USER_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v / 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-Stream slice: registered m_* outputs and a
// registered s_tready, so neither valid nor ready paths cross it combinationally.
module axis_skid_buf
    import doce_tl_pkg::*;
#(
    parameter int DATA_W = doce_tl_pkg::DATA_W,
    parameter int KEEP_W = doce_tl_pkg::KEEP_W,
    parameter int USER_W = doce_tl_pkg::USER_W
) (
    input  logic              user_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic [USER_W-1:0] s_tuser,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [USER_W-1:0] m_tuser,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    beat_t      head;
    beat_t      tail;
    beat_t      in_beat;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_beat  = {s_tdata, s_tkeep, s_tuser, s_tlast};
    assign s_tready = (count != 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    // head always drives the output; tail only fills while the output stalls.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            count <= 2'd0;
            // NOTE: payload registers are reset too so m_tdata/m_tkeep/m_tuser read zero after reset.
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= in_beat;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= in_beat;
                    end else if (push) begin
                        tail  <= in_beat;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign {m_tdata, m_tkeep, m_tuser, m_tlast} = head;

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granularity round-robin arbiter sharing one AXI-Stream egress among
// NUM_REQ requesters; a grant is held from first beat through tlast.
module tx_pkt_arbiter
    import doce_tl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = doce_tl_pkg::DATA_W,
    parameter int KEEP_W  = doce_tl_pkg::KEEP_W,
    parameter int USER_W  = doce_tl_pkg::USER_W
) (
    input  logic                      user_clk,
    input  logic                      reset,
    input  logic [NUM_REQ*DATA_W-1:0] s_tdata,
    input  logic [NUM_REQ*KEEP_W-1:0] s_tkeep,
    input  logic [NUM_REQ*USER_W-1:0] s_tuser,
    input  logic [NUM_REQ-1:0]        s_tvalid,
    input  logic [NUM_REQ-1:0]        s_tlast,
    output logic [NUM_REQ-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic [USER_W-1:0]         m_tuser,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy
);

    localparam int GID_W = clog2(NUM_REQ);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [GID_W-1:0]  grant_next;
    logic [GID_W-1:0]  cand;
    logic              found;
    logic              sel_valid;
    logic              sel_ready;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic [USER_W-1:0] sel_user;

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            grant_id <= GID_W'(NUM_REQ - 1);
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        s_tready   = '0;
        found      = 1'b0;
        cand       = '0;
        case (state)
            ARB_IDLE: begin
                // Search upward from the last winner so it gets lowest priority.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = GID_W'((int'(grant_id) + k) % NUM_REQ);
                    if (!found && s_tvalid[cand]) begin
                        found      = 1'b1;
                        grant_next = cand;
                        state_next = ARB_XFER;
                    end
                end
            end
            ARB_XFER: begin
                s_tready[grant_id] = sel_ready;
                if (sel_valid && sel_ready && sel_last) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign sel_valid = (state == ARB_XFER) && s_tvalid[grant_id];
    assign sel_last  = s_tlast[grant_id];
    assign sel_data  = s_tdata[int'(grant_id)*DATA_W +: DATA_W];
    assign sel_keep  = s_tkeep[int'(grant_id)*KEEP_W +: KEEP_W];
    assign sel_user  = s_tuser[int'(grant_id)*USER_W +: USER_W];
    assign busy      = (state == ARB_XFER);

    axis_skid_buf #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .USER_W(USER_W)
    ) u_skid (
        .user_clk(user_clk),
        .reset   (reset),
        .s_tdata (sel_data),
        .s_tkeep (sel_keep),
        .s_tuser (sel_user),
        .s_tvalid(sel_valid),
        .s_tlast (sel_last),
        .s_tready(sel_ready),
        .m_tdata (m_tdata),
        .m_tkeep (m_tkeep),
        .m_tuser (m_tuser),
        .m_tvalid(m_tvalid),
        .m_tlast (m_tlast),
        .m_tready(m_tready)
    );

endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
Packet-granularity round-robin arbiter that shares the single 128-bit AXI-Stream egress toward the router among NUM_REQ transport-layer requesters (e.g. request, response, ACK/NAK channels).
- A grant is held from the first accepted beat through the tlast beat; packets are never interleaved.
- Output is registered through a 2-entry skid buffer, so the router sees registered valid/data and the upstream tready path is cut.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8)
- DATA_W, 128, tdata width
- KEEP_W, 16, tkeep width (DATA_W/8)
- USER_W, 4, tuser width, forwarded unchanged per beat

Ports:
- user_clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_tdata  in  NUM_REQ*DATA_W  requester data, requester i at [i*DATA_W +: DATA_W]
- s_tkeep  in  NUM_REQ*KEEP_W  requester byte enables
- s_tuser  in  NUM_REQ*USER_W  requester sideband
- s_tvalid  in  NUM_REQ  per-requester valid
- s_tlast  in  NUM_REQ  per-requester end of packet
- s_tready  out  NUM_REQ  per-requester ready, one-hot or zero
- m_tdata  out  DATA_W  to router
- m_tkeep  out  KEEP_W  to router
- m_tuser  out  USER_W  to router
- m_tvalid  out  1  to router
- m_tlast  out  1  to router
- m_tready  in  1  from router
- grant_id  out  clog2(NUM_REQ)  index of the current/last granted requester
- busy  out  1  high while a packet is in flight (state XFER)

Behaviour:
- Clock and reset are exactly: reset reset, synchronous, active-high; clock user_clk.
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata/m_tkeep/m_tuser=0.
  - s_tready=0, busy=0, grant_id=NUM_REQ-1 (round-robin pointer; requester 0 wins first), state=IDLE.
  - Skid buffer is emptied and in-flight beats are discarded. Reset mid-packet simply drops the remainder; requesters restart their packet after reset.
- FSM states:
  - IDLE:
    - If any s_tvalid is set, pick the first set bit searching upward from (grant_id+1) mod NUM_REQ with wrap.
    - Register grant_id to that index and go to XFER (1 cycle arbitration latency).
    - No s_tready is asserted in IDLE.
  - XFER:
    - s_tready[grant_id] = skid buffer not full; all other s_tready = 0.
    - Beat transfer is s_tvalid[g] & s_tready[g]; the selected beat is written into the skid buffer.
    - On a transfer with s_tlast[g]=1, go to IDLE next cycle.
    - Otherwise stay in XFER; gaps with s_tvalid[g]=0 keep the grant.
- Non-granted requesters are never blocked by the granted one beyond packet boundaries. Worst-case wait is NUM_REQ-1 packets.
- Fairness: the pointer advances only at arbitration. A requester that just finished has lowest priority next round.
- Back-to-back packets: minimum one idle arbitration cycle between packets on the s side. The m side may still stream continuously from the skid buffer.
- Skid buffer:
  - Latency 1 cycle from s-side accept to m_tvalid.
  - Full throughput of 1 beat/cycle while m_tready=1.
  - With m_tready=0: holds up to 2 beats; s_tready deasserts the cycle after it becomes full.
  - m_* are stable while m_tvalid=1 and m_tready=0.
  - Simultaneous push and pop when full is not possible; simultaneous push and pop when holding 1 beat keeps the count at 1.
- tkeep/tuser/tdata are passed through unmodified. No packet length checking; a requester that never asserts tlast holds the link indefinitely.
- busy = (state==XFER).

Decomposition:
- Package doce_tl_pkg holds:
  - AXIS width constants (DATA_W=128, KEEP_W=16, USER_W=4).
  - FSM state localparams ARB_IDLE/ARB_XFER.
  - A clog2 function.
- Sub-module axis_skid_buf (parameters DATA_W/KEEP_W/USER_W): 2-entry registered slice with s_/m_ AXIS ports and user_clk/reset. It is reusable for the rx_fsm output path.
- Round-robin selection stays inline as a combinational loop.

Test Plan:
- Single requester: req 2 sends a 3-beat packet with data 0x..01, 0x..02, 0x..03 and m_tready=1 -> grant_id=2 after 1 cycle; m_tvalid beats appear 1 cycle after each accept, in order, m_tlast on the 3rd; busy returns to 0.
- All 4 requesters valid with 2-beat packets -> grant order 0,1,2,3,0 from reset; no interleaving; each packet's m_tlast precedes the next packet's first beat.
- Backpressure: m_tready held 0 for 5 cycles mid-packet -> at most 2 beats buffered; s_tready[g]=0 after buffer full; m_* stable; no beat lost or duplicated after release.
- Requester gap: granted req 1 drops s_tvalid for 3 cycles mid-packet while req 3 is valid -> grant stays 1 until its tlast; req 3 is granted next.
- Reset asserted mid-packet (beat 2 of 4) -> next cycle m_tvalid=0, s_tready=0, grant_id=NUM_REQ-1; a fresh packet from req 0 is then granted first.
- Random stress: 4 requesters, random valid/m_tready, 1000 packets of 1-16 beats -> scoreboard per-requester packet integrity, no interleaving, no starvation beyond 3 packets.
